// File: rtl/pe_cmd_pkg.sv
// Shared types and helpers for the PE command queue: FSM state encoding,
// word slicing inside a packed command entry, and timeout counter sizing.
package pe_cmd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // LSB of word k in a packed entry made of w-bit words.
    function automatic int arg_slice(input int k, input int w);
        return k * w;
    endfunction

    // Timer must hold 0..timeout-1; keep at least one bit when disabled.
    function automatic int timer_w(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/pe_cmd_fifo.sv
// Synchronous DEPTH-entry FIFO with occupancy count. The head entry is read
// combinationally from storage so the issuing logic can latch it on pop.
module pe_cmd_fifo
    import pe_cmd_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: storage is deliberately not reset; validity is tracked by the
    // pointers and count, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which is what would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_i && !pop_i)      count_d = count_q + 1'b1;
        else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/pe_command_queue.sv
// Buffers host commands and issues them to the PE one at a time, waiting for
// command_done (or a timeout) before issuing the next one.
module pe_command_queue
    import pe_cmd_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_ARGS = 3,
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DATA_W-1:0]          command,
    input  logic [NUM_ARGS*DATA_W-1:0] arguments,
    output logic                       accept,
    output logic                       pe_start,
    output logic [DATA_W-1:0]          pe_command,
    output logic [NUM_ARGS*DATA_W-1:0] pe_arguments,
    input  logic                       pe_busy,
    input  logic                       command_done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     queue_count,
    output logic                       overflow,
    output logic                       timeout,
    input  logic                       clear_errors
);

    localparam int ENTRY_W = DATA_W * (NUM_ARGS + 1);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int TIMER_W = timer_w(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    state_e                     state_q, state_d;
    logic [TIMER_W-1:0]         timer_q, timer_d;
    logic                       pe_start_q, pe_start_d;
    logic [DATA_W-1:0]          pe_command_q, pe_command_d;
    logic [NUM_ARGS*DATA_W-1:0] pe_arguments_q, pe_arguments_d;
    logic                       overflow_q, overflow_d;
    logic                       timeout_q, timeout_d;

    logic               push, issue, done_seen, timed_out;
    logic [ENTRY_W-1:0] head;

    assign accept = (queue_count != CNT_W'(DEPTH));
    assign push   = start & accept;

    pe_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (issue),
        .wdata_i ({arguments, command}),
        .rdata_o (head),
        .count_o (queue_count)
    );

    // A done coincident with the issue pulse belongs to the previous command.
    assign issue     = (state_q == IDLE) && (queue_count != '0) && !pe_busy;
    assign done_seen = (state_q == WAIT) && command_done && !pe_start_q;
    assign timed_out = (TIMEOUT != 0) && (state_q == WAIT) && !done_seen &&
                       (timer_q == TIMER_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (issue) state_d = WAIT;
            WAIT: if (done_seen || timed_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pe_start_d     = issue;
        pe_command_d   = pe_command_q;
        pe_arguments_d = pe_arguments_q;
        timer_d        = timer_q;
        if (issue) begin
            pe_command_d   = head[arg_slice(0, DATA_W) +: DATA_W];
            pe_arguments_d = head[arg_slice(1, DATA_W) +: NUM_ARGS*DATA_W];
            timer_d        = '0;
        end else if (state_q == WAIT) begin
            timer_d = timer_q + 1'b1;
        end
        // A new error event in the same cycle as a clear keeps the flag set.
        overflow_d = (overflow_q & ~clear_errors) | (start & ~accept);
        timeout_d  = (timeout_q & ~clear_errors) | timed_out;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q        <= '0;
            pe_start_q     <= 1'b0;
            pe_command_q   <= '0;
            pe_arguments_q <= '0;
            overflow_q     <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            timer_q        <= timer_d;
            pe_start_q     <= pe_start_d;
            pe_command_q   <= pe_command_d;
            pe_arguments_q <= pe_arguments_d;
            overflow_q     <= overflow_d;
            timeout_q      <= timeout_d;
        end
    end

    assign pe_start     = pe_start_q;
    assign pe_command   = pe_command_q;
    assign pe_arguments = pe_arguments_q;
    assign overflow     = overflow_q;
    assign timeout      = timeout_q;
    assign busy         = (queue_count != '0) | (state_q == WAIT) | pe_start_q;

endmodule

// File: doc/pe_command_queue.md
Name: pe_command_queue

Overview:
- Parametrised command front-end for the processing element (PE).
- Buffers host commands, each with NUM_ARGS arguments, in a DEPTH-entry FIFO.
- Issues buffered commands to the PE one at a time and waits for command_done, with a timeout.
- Sits between the host/AXI command writer and the PE; successor to the fixed 3-argument, unbuffered command path.

Parameters:
DATA_W, 32, width of command and each argument
NUM_ARGS, 3, arguments per command (1..8)
DEPTH, 4, FIFO entries (power of two, >=2)
TIMEOUT, 1024, max cycles waiting for command_done; 0 disables timeout

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  push request; command/arguments valid this cycle
command  in  DATA_W  command word
arguments  in  NUM_ARGS*DATA_W  argument k at bits [k*DATA_W +: DATA_W]
accept  out  1  queue not full; push succeeds when start & accept
pe_start  out  1  one-cycle issue pulse to PE
pe_command  out  DATA_W  registered command, held until next issue
pe_arguments  out  NUM_ARGS*DATA_W  registered arguments, held until next issue
pe_busy  in  1  PE cannot accept a new command
command_done  in  1  PE finished current command
busy  out  1  queue non-empty or command in flight
queue_count  out  $clog2(DEPTH)+1  entries stored
overflow  out  1  sticky: start seen while full
timeout  out  1  sticky: command_done not seen within TIMEOUT cycles
clear_errors  in  1  clears overflow and timeout

Behaviour:
- Reset (async assert, sync release) values:
  - accept=1, pe_start=0, pe_command=0, pe_arguments=0, busy=0, queue_count=0, overflow=0, timeout=0
  - FIFO pointers=0, state=IDLE, timer=0
- FIFO: registered storage; write at wr_ptr, read at rd_ptr; pointers wrap modulo DEPTH.
- accept = (queue_count != DEPTH); combinational from the registered count.
- Push: start & accept. Push while full (start & !accept): data dropped, overflow<=1.
- Push and pop in the same cycle: both occur, queue_count unchanged. Full+pop+start still rejects the push (accept is from the registered count).
- State machine:
  - IDLE: if queue_count!=0 & !pe_busy -> latch head into pe_command/pe_arguments, pe_start<=1, pop, timer<=0, go WAIT.
  - WAIT: pe_start<=0; timer increments each cycle.
    - command_done=1 -> go IDLE.
    - Else, if TIMEOUT!=0 and timer==TIMEOUT-1 -> timeout<=1, go IDLE (command abandoned).
- command_done:
  - Sampled only in WAIT. In IDLE it is ignored.
  - command_done in the cycle pe_start is high is ignored, because the state is still IDLE->WAIT transition.
- Back-to-back: after done, earliest next pe_start is 2 cycles after command_done sampled (IDLE cycle registers pe_start).
- Latency: start in cycle t, queue empty, IDLE, pe_busy=0 -> entry visible t+1, pe_start high in cycle t+2.
- busy = (queue_count!=0) | (state==WAIT) | pe_start.
- Errors: clear_errors clears both flags next cycle. A set event in the same cycle as clear_errors wins (flag stays 1).
- Reset mid-operation: in-flight command and all queued entries discarded; no pe_start until new pushes.
- pe_command/pe_arguments change only on issue.

Decomposition:
- Package pe_cmd_pkg:
  - state enum {IDLE, WAIT}
  - function arg_slice(k) for argument indexing
  - TIMER_W derivation constant
- One sub-module: pe_cmd_fifo (parametrised DATA_W*(NUM_ARGS+1) x DEPTH synchronous FIFO with count). The FSM and error logic stay in the top.

Test Plan:
- Single command: push cmd=0x11, args=(1,2,3), pe_busy=0 -> pe_start high exactly cycle t+2, pe_command=0x11, pe_arguments={3,2,1}. Done 5 cycles later -> busy drops next cycle.
- Fill/overflow, DEPTH=4: hold pe_busy=1, push 5 commands -> accept=0 after 4th, queue_count=4, 5th dropped, overflow=1. Release pe_busy -> 4 issues in FIFO order, never the 5th.
- Simultaneous push/pop: queue_count=2, push in the issue cycle -> queue_count stays 2. Next issued command is the older head.
- Timeout, TIMEOUT=8: issue, never assert command_done -> timeout=1 exactly 8 cycles after pe_start, state IDLE, next queued command issues. clear_errors -> timeout=0.
- Spurious done: command_done pulsed in IDLE and in the pe_start cycle -> ignored. The real done later ends WAIT.
- Reset mid-WAIT with 3 queued: assert reset asynchronously -> all outputs to reset values immediately. After release, no pe_start; queue_count=0.
